// File: rtl/music_seq_pkg.sv
// Shared types and constants for the music_seq note sequencer.
// The GAP state only exists when MUSIC_SEQ_GAP_EN is defined.
package music_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_PLAY  = 3'd3,
`ifdef MUSIC_SEQ_GAP_EN
        S_GAP   = 3'd4,
`endif
        S_PAUSE = 3'd5
    } state_t;

    // ROM word layout is {duration, half_period}, half_period in the low bits.
    localparam int TONE_LSB   = 0;
    localparam int END_MARKER = 0;

    function automatic int dur_lsb(input int tone_w);
        return TONE_LSB + tone_w;
    endfunction

endpackage

// File: rtl/music_seq_if.sv
// Note ROM fetch bus: music_seq drives the address and read strobe,
// the synchronous ROM returns the word one cycle after the strobe.
interface music_seq_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 20
);
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rd;
    logic [DATA_W-1:0] rom_data;

    modport master (output rom_addr, output rom_rd, input rom_data);
    modport slave  (input rom_addr, input rom_rd, output rom_data);
endinterface

// File: rtl/music_seq_tone_gen.sv
// Square-wave tone generator: half-period down-counter plus output toggle.
// The phase survives while disabled so a paused note resumes mid-period.
module tone_gen #(
    parameter int TONE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [TONE_W-1:0] half_period,
    input  logic              en,
    input  logic              audible,
    output logic              pwm_out
);

    logic [TONE_W-1:0] half_q;
    logic [TONE_W-1:0] cnt;
    logic [TONE_W-1:0] cnt_n;
    logic              phase;
    logic              phase_n;
    logic              is_rest;

    always_comb begin
        cnt_n   = cnt;
        phase_n = phase;
        if (load) begin
            cnt_n   = half_period - TONE_W'(1);
            phase_n = 1'b0;
        end else if (en) begin
            if (cnt == '0) begin
                cnt_n   = half_q - TONE_W'(1);
                phase_n = ~phase;
            end else begin
                cnt_n = cnt - TONE_W'(1);
            end
        end
    end

    // A zero half-period is a rest; the counter still runs but the pin stays low.
    assign is_rest = load ? (half_period == '0) : (half_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            half_q  <= '0;
            cnt     <= '0;
            phase   <= 1'b0;
            pwm_out <= 1'b0;
        end else begin
            if (load) begin
                half_q <= half_period;
            end
            cnt     <= cnt_n;
            phase   <= phase_n;
            pwm_out <= audible && !is_rest && phase_n;
        end
    end

endmodule

// File: rtl/music_seq.sv
// Note sequencer: fetches {duration, half_period} words, plays each note,
// walks to the end marker. Optional articulation gap via MUSIC_SEQ_GAP_EN.
module music_seq
    import music_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int TONE_W   = 16,
    parameter int LEN_W    = 4,
    parameter int BEAT_CYC = 12_500_000,
    parameter int GAP_CYC  = 1_250_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        stop,
    input  logic        loop_en,
    music_seq_if.master rom,
    output logic        pwm_out,
    output logic        busy,
    output logic        done
);

    localparam int DUR_LSB = dur_lsb(TONE_W);
    localparam int BEAT_W  = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYC - 1);

    state_t            state, state_n;
    state_t            ret, ret_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [BEAT_W-1:0] beat, beat_n;
    logic [LEN_W-1:0]  beats_left, beats_left_n;
    logic              rd_q;
    logic              done_n;
    logic              tone_load;
    logic              finish_song;
    logic [LEN_W-1:0]  dur;
    logic [TONE_W-1:0] half;

`ifdef MUSIC_SEQ_GAP_EN
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    logic [GAP_W-1:0] gap_cnt, gap_n;
    logic             wrap_q, wrap_n;
`endif

    assign dur          = rom.rom_data[DUR_LSB +: LEN_W];
    assign half         = rom.rom_data[TONE_LSB +: TONE_W];
    assign rom.rom_addr = addr;
    assign rom.rom_rd   = rd_q;

    always_comb begin
        state_n      = state;
        ret_n        = ret;
        addr_n       = addr;
        beat_n       = beat;
        beats_left_n = beats_left;
        done_n       = 1'b0;
        tone_load    = 1'b0;
        finish_song  = 1'b0;
`ifdef MUSIC_SEQ_GAP_EN
        gap_n        = gap_cnt;
        wrap_n       = wrap_q;
`endif
        if (stop) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_n = S_FETCH;
                        addr_n  = '0;
                    end
                end
                S_FETCH: state_n = S_WAIT;
                S_WAIT: begin
                    if (dur == LEN_W'(END_MARKER)) begin
                        finish_song = 1'b1;
                    end else begin
                        tone_load    = 1'b1;
                        beat_n       = BEAT_LAST;
                        beats_left_n = dur - LEN_W'(1);
                        state_n      = S_PLAY;
                    end
                end
                S_PLAY: begin
                    // Pause is ignored on the final cycle of a note; it is picked up next PLAY/GAP cycle.
                    if (beat == '0 && beats_left == '0) begin
`ifdef MUSIC_SEQ_GAP_EN
                        gap_n   = GAP_LAST;
                        wrap_n  = &addr;
                        state_n = S_GAP;
                        if (!(&addr)) begin
                            addr_n = addr + ADDR_W'(1);
                        end
`else
                        if (&addr) begin
                            finish_song = 1'b1;
                        end else begin
                            addr_n  = addr + ADDR_W'(1);
                            state_n = S_FETCH;
                        end
`endif
                    end else begin
                        if (beat == '0) begin
                            beat_n       = BEAT_LAST;
                            beats_left_n = beats_left - LEN_W'(1);
                        end else begin
                            beat_n = beat - BEAT_W'(1);
                        end
                        if (pause) begin
                            ret_n   = S_PLAY;
                            state_n = S_PAUSE;
                        end
                    end
                end
`ifdef MUSIC_SEQ_GAP_EN
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        if (wrap_q) begin
                            finish_song = 1'b1;
                        end else begin
                            state_n = S_FETCH;
                        end
                    end else begin
                        gap_n = gap_cnt - GAP_W'(1);
                        if (pause) begin
                            ret_n   = S_GAP;
                            state_n = S_PAUSE;
                        end
                    end
                end
`endif
                S_PAUSE: begin
                    if (!pause) begin
                        state_n = ret;
                    end
                end
                default: state_n = S_IDLE;
            endcase

            // A marker word and running off the last address end the song the same way.
            if (finish_song) begin
                if (loop_en) begin
                    addr_n  = '0;
                    state_n = S_FETCH;
                end else begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ret        <= S_IDLE;
            addr       <= '0;
            beat       <= '0;
            beats_left <= '0;
            rd_q       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef MUSIC_SEQ_GAP_EN
            gap_cnt    <= '0;
            wrap_q     <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            ret        <= ret_n;
            addr       <= addr_n;
            beat       <= beat_n;
            beats_left <= beats_left_n;
            rd_q       <= (state_n == S_FETCH);
            busy       <= (state_n != S_IDLE);
            done       <= done_n;
`ifdef MUSIC_SEQ_GAP_EN
            gap_cnt    <= gap_n;
            wrap_q     <= wrap_n;
`endif
        end
    end

    tone_gen #(
        .TONE_W (TONE_W)
    ) u_tone (
        .clk         (clk),
        .rst         (rst),
        .load        (tone_load),
        .half_period (half),
        .en          (state == S_PLAY),
        .audible     (state_n == S_PLAY),
        .pwm_out     (pwm_out)
    );

endmodule

// File: tb/tb_music_seq.sv
// Testbench for music_seq: control-vector table plus song traces predicted
// from the ROM contents, with random songs, pauses and stray start pulses.
module tb_music_seq;

    localparam int ADDR_W = 3;
    localparam int TONE_W = 16;
    localparam int LEN_W  = 4;
    localparam int BEAT   = 4;
    localparam int GAPC   = 2;
`ifdef MUSIC_SEQ_GAP_EN
    localparam int GAP_LEN = GAPC;
`else
    localparam int GAP_LEN = 0;
`endif

    typedef struct packed {
        logic       pz;
        logic       pwm;
        logic       busy;
        logic       done;
        logic       rd;
        logic [2:0] addr;
    } cyc_t;

    typedef struct {
        logic start;
        logic stop;
        logic pause;
        logic exp_busy;
        logic exp_rd;
    } ctl_vec_t;

    logic clk = 1'b0;
    logic rst, start, pause, stop, loop_en;
    logic pwm_out, busy, done;

    logic [LEN_W+TONE_W-1:0] mem [8];
    cyc_t     trace[$];
    bit       song_ended;
    ctl_vec_t tbl [7];
    int       vectors = 0;
    int       miscompares = 0;

    music_seq_if #(.ADDR_W(ADDR_W), .DATA_W(LEN_W + TONE_W)) rom ();

    music_seq #(
        .ADDR_W   (ADDR_W),
        .TONE_W   (TONE_W),
        .LEN_W    (LEN_W),
        .BEAT_CYC (BEAT),
        .GAP_CYC  (GAPC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pause   (pause),
        .stop    (stop),
        .loop_en (loop_en),
        .rom     (rom),
        .pwm_out (pwm_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom.rom_rd) rom.rom_data <= mem[rom.rom_addr];
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [LEN_W+TONE_W-1:0] word(input int d, input int h);
        return {4'(d), 16'(h)};
    endfunction

    function automatic cyc_t mk(input logic pz, input logic pwm, input logic bsy,
                                input logic dn, input logic rd, input int a);
        cyc_t c;
        c.pz   = pz;
        c.pwm  = pwm;
        c.busy = bsy;
        c.done = dn;
        c.rd   = rd;
        c.addr = 3'(a);
        return c;
    endfunction

    // Expected per-cycle outputs from the song rules: FETCH, WAIT, dur*BEAT play cycles, gap.
    function automatic void buildTrace(input bit lp, input int limit, input int pause_at, input int pause_len);
        int  a = 0;
        int  plays = 0;
        bit  paused = 0;
        int  d, h;
        logic p;
        trace.delete();
        song_ended = 0;
        while (trace.size() < limit) begin
            trace.push_back(mk(0, 0, 1, 0, 1, a));
            trace.push_back(mk(0, 0, 1, 0, 0, a));
            d = int'(mem[a][19:16]);
            h = int'(mem[a][15:0]);
            if (d == 0) begin
                if (lp) begin
                    a = 0;
                    continue;
                end
                trace.push_back(mk(0, 0, 0, 1, 0, a));
                song_ended = 1;
                break;
            end
            for (int i = 0; i < d * BEAT; i++) begin
                p = (h != 0) && (((i / h) % 2) == 1);
                if (!paused && pause_len > 0 && plays >= pause_at && i != d * BEAT - 1) begin
                    paused = 1;
                    trace.push_back(mk(1, p, 1, 0, 0, a));
                    for (int k = 0; k < pause_len; k++)
                        trace.push_back(mk(k < pause_len - 1, 0, 1, 0, 0, a));
                end else begin
                    trace.push_back(mk(0, p, 1, 0, 0, a));
                end
                plays++;
            end
            for (int g = 0; g < GAP_LEN; g++) trace.push_back(mk(0, 0, 1, 0, 0, a));
            if (a == 7) begin
                if (lp) begin
                    a = 0;
                end else begin
                    trace.push_back(mk(0, 0, 0, 1, 0, a));
                    song_ended = 1;
                    break;
                end
            end else begin
                a++;
            end
        end
    endfunction

    task automatic checkOutput(input string name, input int idx, input cyc_t e, input bit chk_addr);
        bit bad;
        vectors++;
        bad = (pwm_out !== e.pwm) || (busy !== e.busy) || (done !== e.done) ||
              (rom.rom_rd !== e.rd) || ((e.rd || chk_addr) && (rom.rom_addr !== e.addr));
        if (bad) begin
            miscompares++;
            $display("[TB] FAIL %s[%0d]: pwm/busy/done/rd/addr got %b/%b/%b/%b/%0d, expected %b/%b/%b/%b/%0d",
                     name, idx, pwm_out, busy, done, rom.rom_rd, rom.rom_addr,
                     e.pwm, e.busy, e.done, e.rd, e.addr);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic st, input logic p);
        start = s;
        stop  = st;
        pause = p;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
    endtask

    // Starts the song, compares up to 'upto' trace cycles; a full run also checks the idle tail.
    task automatic runTrace(input string name, input int upto);
        int n;
        n = (upto < trace.size()) ? upto : trace.size();
        @(negedge clk);
        start = 1'b1;
        pause = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            checkOutput(name, i, trace[i], 0);
            pause = trace[i].pz;
            if (trace[i].busy && $urandom_range(0, 7) == 0) start = 1'b1;
        end
        if (upto >= trace.size()) begin
            if (!song_ended) stop = 1'b1;
            start = 1'b0;
            pause = 1'b0;
            @(negedge clk);
            stop = 1'b0;
            checkOutput({name, "_end"}, n, mk(0, 0, 0, 0, 0, 0), 0);
        end
    endtask

    task automatic clearRom();
        for (int i = 0; i < 8; i++) mem[i] = '0;
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; loop_en = 1'b0;
        clearRom();
        repeat (3) @(negedge clk);
        checkOutput("reset", 0, mk(0, 0, 0, 0, 0, 0), 1);
        rst = 1'b0;

        mem[0] = word(2, 3);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(tbl[i].start, tbl[i].stop, tbl[i].pause);
            checkOutput("ctl", i, mk(0, 0, tbl[i].exp_busy, 0, tbl[i].exp_rd, 0), 0);
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput("ctl_stop", i, mk(0, 0, 0, 0, 0, 0), 0);
        end

        clearRom(); mem[0] = word(2, 3);
        buildTrace(0, 400, 0, 0);
        runTrace("single", 1 << 30);

        clearRom(); mem[0] = word(1, 0);
        buildTrace(0, 400, 0, 0);
        runTrace("rest", 1 << 30);

        clearRom(); mem[0] = word(2, 3);
        buildTrace(0, 400, 2, 10);
        runTrace("pause", 1 << 30);

        clearRom(); mem[0] = word(1, 2);
        loop_en = 1'b1;
        buildTrace(1, 40, 0, 0);
        runTrace("loop", 1 << 30);
        loop_en = 1'b0;

        for (int i = 0; i < 8; i++) mem[i] = word(1, i % 4);
        buildTrace(0, 400, 0, 0);
        runTrace("wrap", 1 << 30);

        clearRom();
        buildTrace(0, 400, 0, 0);
        runTrace("empty", 1 << 30);

        mem[0] = word(2, 3);
        buildTrace(0, 400, 0, 0);
        runTrace("rst_mid", 6);
        rst = 1'b1; start = 1'b0; pause = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_reset", 0, mk(0, 0, 0, 0, 0, 0), 1);
        rst = 1'b0;
        runTrace("rst_after", 1 << 30);

        for (int r = 0; r < 12; r++) begin
            int pl;
            for (int i = 0; i < 8; i++)
                mem[i] = word(($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 3), $urandom_range(0, 5));
            loop_en = ($urandom_range(0, 3) == 0);
            pl = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0;
            buildTrace(loop_en, 150, $urandom_range(0, 15), pl);
            runTrace("rand", 1 << 30);
            loop_en = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
